// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron datapath readout: accumulator
// geometry, packet framing byte and the dump state encoding.
package perceptron_pkg;

    localparam int         ACC_WIDTH  = 128;
    localparam logic [7:0] PKT_HEADER = 8'hA5;
    localparam int         NBYTES     = ACC_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_t;

endpackage

// File: rtl/acc_dump_if.sv
// Bundle between the controller/UART side and the accumulator dump stage.
// The slave modport is the dump stage itself; master is whoever drives it.
interface acc_dump_if #(
    parameter int WIDTH = perceptron_pkg::ACC_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] big;
    logic             busy_tx;
    logic             transmit;
    logic [7:0]       data_tx;
    logic             busy;
    logic             done;

    modport master (
        output start, big, busy_tx,
        input  transmit, data_tx, busy, done
    );

    modport slave (
        input  start, big, busy_tx,
        output transmit, data_tx, busy, done
    );
endinterface

// File: rtl/acc_dump.sv
// Accumulator readout stage: on start, snapshots the accumulator and streams
// it to the UART as header, WIDTH/8 data bytes MSB-first, then an XOR
// checksum of the data bytes. Pacing follows the UART busy_tx handshake,
// with a timeout in case the transmitter never acknowledges a strobe.
// WIDTH must be a multiple of 8 and ACK_TIMEOUT at least 1.
module acc_dump
    import perceptron_pkg::*;
#(
    parameter int         WIDTH       = ACC_WIDTH,
    parameter logic [7:0] HEADER      = PKT_HEADER,
    parameter int         ACK_TIMEOUT = 15
) (
    input logic       clk,
    input logic       rst,
    acc_dump_if.slave bus
);

    localparam int DUMP_BYTES = WIDTH / 8;
    localparam int IDX_W      = $clog2(DUMP_BYTES + 2);
    localparam int TIMER_W    = $clog2(ACK_TIMEOUT + 1);

    // idx value of the checksum byte, and of the last data byte before it
    localparam logic [IDX_W-1:0]   IDX_CSUM   = IDX_W'(DUMP_BYTES + 1);
    localparam logic [IDX_W-1:0]   IDX_LAST_D = IDX_W'(DUMP_BYTES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

    dump_state_t        state;
    logic [WIDTH-1:0]   snap;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         csum;
    logic [TIMER_W-1:0] timer;
    logic               transmit_q;
    logic [7:0]         data_tx_q;
    logic               busy_q;
    logic               done_q;

    assign bus.transmit = transmit_q;
    assign bus.data_tx  = data_tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Packet sequencer: the outgoing byte is loaded on the transition into
    // SEND so transmit and data_tx are registered together; the snapshot
    // shifts left as each data byte leaves, so the next byte is always on top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            snap       <= '0;
            idx        <= '0;
            csum       <= '0;
            timer      <= '0;
            transmit_q <= 1'b0;
            data_tx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        snap       <= bus.big;
                        idx        <= '0;
                        csum       <= '0;
                        data_tx_q  <= HEADER;
                        transmit_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    transmit_q <= 1'b0;
                    timer      <= '0;
                    state      <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (bus.busy_tx || timer == TIMER_LAST) begin
                        state <= ST_WAIT_LO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.busy_tx) begin
                        if (idx == IDX_CSUM) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            transmit_q <= 1'b1;
                            state      <= ST_SEND;
                            if (idx == IDX_LAST_D) begin
                                data_tx_q <= csum;
                            end else begin
                                data_tx_q <= snap[WIDTH-1 -: 8];
                                csum      <= csum ^ snap[WIDTH-1 -: 8];
                                snap      <= snap << 8;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_dump.sv
// Testbench for acc_dump: a behavioural UART responder answers each strobe,
// a monitor records every strobe and done pulse, and each packet is compared
// against a reference packet built directly from the accumulator value.
module tb_acc_dump;
    import perceptron_pkg::*;

    localparam int TOUT = 15;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    int   cyc       = 0;
    int   uart_hold = 1;
    int   hold_cnt  = 0;
    logic [7:0] strobe_q[$];
    int         strobe_cyc[$];
    int         done_cyc[$];
    logic [7:0] exp_q[$];

    acc_dump_if #(.WIDTH(ACC_WIDTH)) bus ();

    acc_dump #(
        .WIDTH(ACC_WIDTH),
        .HEADER(PKT_HEADER),
        .ACK_TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model plus monitor: busy_tx stays high for uart_hold cycles after
    // each strobe (0 means never); strobes and done pulses are logged by cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            hold_cnt = 0;
            bus.busy_tx = 1'b0;
        end else begin
            if (hold_cnt > 0) begin
                bus.busy_tx = 1'b1;
                hold_cnt = hold_cnt - 1;
            end else begin
                bus.busy_tx = 1'b0;
            end
            if (bus.transmit === 1'b1) begin
                strobe_q.push_back(bus.data_tx);
                strobe_cyc.push_back(cyc);
                hold_cnt = uart_hold;
            end
            if (bus.done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference packet: header, bytes of v from the most significant down, XOR of data bytes
    task automatic make_expected(input logic [ACC_WIDTH-1:0] v);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(PKT_HEADER);
        for (int i = 0; i < NBYTES; i++) begin
            b = v[8*(NBYTES-1-i) +: 8];
            x = x ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(x);
    endtask

    task automatic clear_log();
        strobe_q.delete();
        strobe_cyc.delete();
        done_cyc.delete();
    endtask

    // One-cycle start pulse with the given accumulator value
    task automatic applyStimulus(input logic [ACC_WIDTH-1:0] v);
        bus.big = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Wait for the next done pulse; optionally require busy high throughout
    task automatic wait_done(input string tag, input int target, input bit check_busy);
        int n = 0;
        int busy_low = 0;
        while (done_cyc.size() < target && n < 1000) begin
            step();
            if (bus.busy !== 1'b1) busy_low++;
            n++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done_cyc.size() >= target), 64'd1);
        if (check_busy) checkOutput({tag, "_busy_gaps"}, 64'(busy_low), 64'd0);
    endtask

    task automatic check_packet(input string tag);
        int n;
        checkOutput({tag, "_len"}, 64'(strobe_q.size()), 64'(exp_q.size()));
        n = (strobe_q.size() < exp_q.size()) ? strobe_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 64'(strobe_q[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [ACC_WIDTH-1:0] rand_acc();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [ACC_WIDTH-1:0] v;
        int start_cyc;
        int d;
        int n;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.big = '0;
        bus.busy_tx = 1'b0;
        repeat (3) step();
        checkOutput("rst_transmit", 64'(bus.transmit), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_data_tx", 64'(bus.data_tx), 64'd0);
        rst = 1'b0;
        step();
        clear_log();

        // Ideal UART, counting pattern
        $display("[TB] ideal UART, counting pattern");
        uart_hold = 1;
        v = 128'h0F0E0D0C0B0A09080706050403020100;
        make_expected(v);
        start_cyc = cyc;
        applyStimulus(v);
        checkOutput("ideal_busy_rise", 64'(bus.busy), 64'd1);
        wait_done("ideal", 1, 1'b1);
        repeat (3) step();
        check_packet("ideal");
        checkOutput("ideal_csum", 64'(exp_q[NBYTES+1]), 64'h00);
        if (strobe_cyc.size() > 0)
            checkOutput("ideal_first_cyc", 64'(strobe_cyc[0]), 64'(start_cyc + 1));
        for (int i = 1; i < strobe_cyc.size(); i++)
            checkOutput($sformatf("ideal_gap%0d", i), 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd3);
        checkOutput("ideal_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0 && strobe_cyc.size() > 0)
            checkOutput("ideal_done_cyc", 64'(done_cyc[0]), 64'(strobe_cyc[strobe_cyc.size()-1] + 3));
        checkOutput("ideal_busy_after", 64'(bus.busy), 64'd0);
        checkOutput("ideal_data_hold", 64'(bus.data_tx), 64'(exp_q[NBYTES+1]));
        clear_log();

        // Slow UART, single nonzero low byte
        $display("[TB] slow UART, low byte only");
        uart_hold = 10;
        v = 128'hFF;
        make_expected(v);
        applyStimulus(v);
        wait_done("slow", 1, 1'b1);
        repeat (3) step();
        check_packet("slow");
        checkOutput("slow_done_count", 64'(done_cyc.size()), 64'd1);
        clear_log();

        // UART never acknowledges: every byte released by the timeout
        $display("[TB] busy_tx tied low");
        uart_hold = 0;
        v = rand_acc();
        make_expected(v);
        applyStimulus(v);
        wait_done("tout", 1, 1'b1);
        repeat (3) step();
        check_packet("tout");
        for (int i = 1; i < strobe_cyc.size(); i++)
            checkOutput($sformatf("tout_gap%0d", i), 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'(TOUT + 2));
        checkOutput("tout_done_count", 64'(done_cyc.size()), 64'd1);
        clear_log();

        // Accumulator changes and start re-pulsed mid-packet
        $display("[TB] start and big changed during byte 5");
        uart_hold = 1;
        v = rand_acc();
        make_expected(v);
        applyStimulus(v);
        n = 0;
        while (strobe_q.size() < 5 && n < 200) begin step(); n++; end
        checkOutput("midstart_reach5", 64'(strobe_q.size() >= 5), 64'd1);
        bus.big = ~v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("midstart", 1, 1'b0);
        repeat (30) step();
        check_packet("midstart");
        checkOutput("midstart_done_count", 64'(done_cyc.size()), 64'd1);
        clear_log();

        // Reset in the middle of a packet, then a fresh dump
        $display("[TB] reset during byte 9");
        v = rand_acc();
        applyStimulus(v);
        n = 0;
        while (strobe_q.size() < 9 && n < 200) begin step(); n++; end
        checkOutput("abort_reach9", 64'(strobe_q.size() >= 9), 64'd1);
        rst = 1'b1;
        step();
        checkOutput("abort_transmit", 64'(bus.transmit), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        clear_log();
        repeat (40) step();
        checkOutput("abort_no_strobes", 64'(strobe_q.size()), 64'd0);
        checkOutput("abort_no_done", 64'(done_cyc.size()), 64'd0);
        v = rand_acc();
        make_expected(v);
        applyStimulus(v);
        wait_done("restart", 1, 1'b1);
        repeat (3) step();
        check_packet("restart");
        clear_log();

        // start held high for 40 cycles gives a single packet
        $display("[TB] start held for 40 cycles");
        v = rand_acc();
        make_expected(v);
        bus.big = v;
        bus.start = 1'b1;
        repeat (40) step();
        bus.start = 1'b0;
        wait_done("held", 1, 1'b0);
        repeat (60) step();
        check_packet("held");
        checkOutput("held_done_count", 64'(done_cyc.size()), 64'd1);
        clear_log();

        // start held through done: next header two cycles after done
        $display("[TB] start held across done");
        v = rand_acc();
        bus.big = v;
        bus.start = 1'b1;
        wait_done("back2back", 1, 1'b0);
        d = (done_cyc.size() > 0) ? done_cyc[0] : 0;
        n = 0;
        while (strobe_q.size() <= NBYTES + 2 && n < 10) begin step(); n++; end
        bus.start = 1'b0;
        checkOutput("b2b_second_started", 64'(strobe_q.size() > NBYTES + 2), 64'd1);
        if (strobe_q.size() > NBYTES + 2) begin
            checkOutput("b2b_second_cyc", 64'(strobe_cyc[NBYTES+2]), 64'(d + 2));
            checkOutput("b2b_second_hdr", 64'(strobe_q[NBYTES+2]), 64'(PKT_HEADER));
        end
        wait_done("b2b_end", 2, 1'b0);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
